// File: rtl/axi_lite_arb2.sv
// Two-master to one-slave AXI-Lite arbiter: round-robin grant, one transaction
// in flight, SLVERR response when the slave fails to answer within TIMEOUT cycles.
module axi_lite_arb2 #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned TIMEOUT    = 1024
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [ADDR_WIDTH-1:0]     m0_awaddr,
  input  logic                      m0_awvalid,
  output logic                      m0_awready,
  input  logic [DATA_WIDTH-1:0]     m0_wdata,
  input  logic [DATA_WIDTH/8-1:0]   m0_wstrb,
  input  logic                      m0_wvalid,
  output logic                      m0_wready,
  output logic [1:0]                m0_bresp,
  output logic                      m0_bvalid,
  input  logic                      m0_bready,
  input  logic [ADDR_WIDTH-1:0]     m0_araddr,
  input  logic                      m0_arvalid,
  output logic                      m0_arready,
  output logic [DATA_WIDTH-1:0]     m0_rdata,
  output logic [1:0]                m0_rresp,
  output logic                      m0_rvalid,
  input  logic                      m0_rready,
  input  logic [ADDR_WIDTH-1:0]     m1_awaddr,
  input  logic                      m1_awvalid,
  output logic                      m1_awready,
  input  logic [DATA_WIDTH-1:0]     m1_wdata,
  input  logic [DATA_WIDTH/8-1:0]   m1_wstrb,
  input  logic                      m1_wvalid,
  output logic                      m1_wready,
  output logic [1:0]                m1_bresp,
  output logic                      m1_bvalid,
  input  logic                      m1_bready,
  input  logic [ADDR_WIDTH-1:0]     m1_araddr,
  input  logic                      m1_arvalid,
  output logic                      m1_arready,
  output logic [DATA_WIDTH-1:0]     m1_rdata,
  output logic [1:0]                m1_rresp,
  output logic                      m1_rvalid,
  input  logic                      m1_rready,
  output logic [ADDR_WIDTH-1:0]     s_awaddr,
  output logic                      s_awvalid,
  input  logic                      s_awready,
  output logic [DATA_WIDTH-1:0]     s_wdata,
  output logic [DATA_WIDTH/8-1:0]   s_wstrb,
  output logic                      s_wvalid,
  input  logic                      s_wready,
  input  logic [1:0]                s_bresp,
  input  logic                      s_bvalid,
  output logic                      s_bready,
  output logic [ADDR_WIDTH-1:0]     s_araddr,
  output logic                      s_arvalid,
  input  logic                      s_arready,
  input  logic [DATA_WIDTH-1:0]     s_rdata,
  input  logic [1:0]                s_rresp,
  input  logic                      s_rvalid,
  output logic                      s_rready,
  output logic [1:0]                grant_o,
  output logic                      timeout_o
);

  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;
  localparam int unsigned CNT_WIDTH  = $clog2(TIMEOUT);
  localparam logic [1:0]  RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {IDLE, W_ADDR, W_RESP, R_ADDR, R_DATA, ERR} state_t;

  state_t               state_q, state_d;
  logic [1:0]           grant_q, grant_d;
  logic                 last_q, last_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d, cnt_inc;
  logic                 aw_done_q, aw_done_d, w_done_q, w_done_d;
  logic                 wr_q, wr_d;
  logic                 timeout_q, timeout_d;
  logic                 expired;

  logic [1:0] req_w, req_r, req;
  logic       pick, sel;

  // Signals of the currently granted master
  logic [ADDR_WIDTH-1:0] g_awaddr, g_araddr;
  logic [DATA_WIDTH-1:0] g_wdata, g_rdata;
  logic [STRB_WIDTH-1:0] g_wstrb;
  logic                  g_awvalid, g_wvalid, g_bready, g_arvalid, g_rready;
  logic                  g_awready, g_wready, g_bvalid, g_arready, g_rvalid;
  logic [1:0]            g_bresp, g_rresp;

  assign req_w = {m1_awvalid & m1_wvalid, m0_awvalid & m0_wvalid};
  assign req_r = {m1_arvalid, m0_arvalid};
  assign req   = req_w | req_r;
  assign pick  = (req == 2'b11) ? ~last_q : req[1];
  assign sel   = grant_q[1];

  assign g_awaddr  = sel ? m1_awaddr  : m0_awaddr;
  assign g_awvalid = sel ? m1_awvalid : m0_awvalid;
  assign g_wdata   = sel ? m1_wdata   : m0_wdata;
  assign g_wstrb   = sel ? m1_wstrb   : m0_wstrb;
  assign g_wvalid  = sel ? m1_wvalid  : m0_wvalid;
  assign g_bready  = sel ? m1_bready  : m0_bready;
  assign g_araddr  = sel ? m1_araddr  : m0_araddr;
  assign g_arvalid = sel ? m1_arvalid : m0_arvalid;
  assign g_rready  = sel ? m1_rready  : m0_rready;

  assign expired = (cnt_q == CNT_WIDTH'(TIMEOUT - 1));
  assign cnt_inc = expired ? cnt_q : cnt_q + CNT_WIDTH'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      grant_q   <= 2'b00;
      last_q    <= 1'b1;
      cnt_q     <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      wr_q      <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      last_q    <= last_d;
      cnt_q     <= cnt_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      wr_q      <= wr_d;
      timeout_q <= timeout_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    last_d    = last_q;
    cnt_d     = cnt_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    wr_d      = wr_q;
    timeout_d = 1'b0;
    s_awaddr  = '0;
    s_awvalid = 1'b0;
    s_wdata   = '0;
    s_wstrb   = '0;
    s_wvalid  = 1'b0;
    s_bready  = 1'b0;
    s_araddr  = '0;
    s_arvalid = 1'b0;
    s_rready  = 1'b0;
    g_awready = 1'b0;
    g_wready  = 1'b0;
    g_bvalid  = 1'b0;
    g_bresp   = 2'b00;
    g_arready = 1'b0;
    g_rvalid  = 1'b0;
    g_rdata   = '0;
    g_rresp   = 2'b00;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (|req) begin
          grant_d = pick ? 2'b10 : 2'b01;
          last_d  = pick;
          wr_d    = req_w[pick];
          state_d = req_w[pick] ? W_ADDR : R_ADDR;
        end
      end
      W_ADDR: begin
        s_awaddr  = g_awaddr;
        s_awvalid = g_awvalid & ~aw_done_q;
        s_wdata   = g_wdata;
        s_wstrb   = g_wstrb;
        s_wvalid  = g_wvalid & ~w_done_q;
        g_awready = s_awready & ~aw_done_q;
        g_wready  = s_wready & ~w_done_q;
        aw_done_d = aw_done_q | (s_awvalid & s_awready);
        w_done_d  = w_done_q | (s_wvalid & s_wready);
        cnt_d     = cnt_inc;
        if (aw_done_d && w_done_d) begin
          state_d = W_RESP;
        end else if (expired) begin
          state_d   = ERR;
          timeout_d = 1'b1;
        end
      end
      W_RESP: begin
        g_bvalid = s_bvalid;
        g_bresp  = s_bresp;
        s_bready = g_bready;
        cnt_d    = cnt_inc;
        if (s_bvalid && g_bready) begin
          state_d = IDLE;
        end else if (expired) begin
          state_d   = ERR;
          timeout_d = 1'b1;
        end
      end
      R_ADDR: begin
        s_araddr  = g_araddr;
        s_arvalid = g_arvalid;
        g_arready = s_arready;
        cnt_d     = cnt_inc;
        if (g_arvalid && s_arready) begin
          state_d = R_DATA;
        end else if (expired) begin
          state_d   = ERR;
          timeout_d = 1'b1;
        end
      end
      R_DATA: begin
        g_rvalid = s_rvalid;
        g_rdata  = s_rdata;
        g_rresp  = s_rresp;
        s_rready = g_rready;
        cnt_d    = cnt_inc;
        if (s_rvalid && g_rready) begin
          state_d = IDLE;
        end else if (expired) begin
          state_d   = ERR;
          timeout_d = 1'b1;
        end
      end
      ERR: begin
        // Swallow any late slave response while the master gets SLVERR
        s_bready = 1'b1;
        s_rready = 1'b1;
        if (wr_q) begin
          g_bvalid = 1'b1;
          g_bresp  = RESP_SLVERR;
          if (g_bready) state_d = IDLE;
        end else begin
          g_rvalid = 1'b1;
          g_rresp  = RESP_SLVERR;
          if (g_rready) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (state_d == IDLE && state_q != IDLE) begin
      grant_d   = 2'b00;
      aw_done_d = 1'b0;
      w_done_d  = 1'b0;
    end
  end

  assign m0_awready = grant_q[0] & g_awready;
  assign m0_wready  = grant_q[0] & g_wready;
  assign m0_bvalid  = grant_q[0] & g_bvalid;
  assign m0_bresp   = grant_q[0] ? g_bresp : 2'b00;
  assign m0_arready = grant_q[0] & g_arready;
  assign m0_rvalid  = grant_q[0] & g_rvalid;
  assign m0_rdata   = grant_q[0] ? g_rdata : '0;
  assign m0_rresp   = grant_q[0] ? g_rresp : 2'b00;

  assign m1_awready = grant_q[1] & g_awready;
  assign m1_wready  = grant_q[1] & g_wready;
  assign m1_bvalid  = grant_q[1] & g_bvalid;
  assign m1_bresp   = grant_q[1] ? g_bresp : 2'b00;
  assign m1_arready = grant_q[1] & g_arready;
  assign m1_rvalid  = grant_q[1] & g_rvalid;
  assign m1_rdata   = grant_q[1] ? g_rdata : '0;
  assign m1_rresp   = grant_q[1] ? g_rresp : 2'b00;

  assign grant_o   = grant_q;
  assign timeout_o = timeout_q;

endmodule

// File: tb/tb_axi_lite_arb2.sv
// Directed bench for axi_lite_arb2: arbitration table plus hand-written
// sequences for split AW/W, timeout, handshake at expiry and mid-read reset.
module tb_axi_lite_arb2;

  logic clk, rst;
  logic [31:0] m_awaddr [2];
  logic [31:0] m_wdata  [2];
  logic [3:0]  m_wstrb  [2];
  logic [31:0] m_araddr [2];
  logic [31:0] m_rdata  [2];
  logic [1:0]  m_bresp  [2];
  logic [1:0]  m_rresp  [2];
  logic [1:0]  m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
  logic [1:0]  m_arvalid, m_arready, m_rvalid, m_rready;
  logic [31:0] s_awaddr, s_wdata, s_araddr, s_rdata;
  logic [3:0]  s_wstrb;
  logic [1:0]  s_bresp, s_rresp, grant_o;
  logic        s_awvalid, s_awready, s_wvalid, s_wready, s_bvalid, s_bready;
  logic        s_arvalid, s_arready, s_rvalid, s_rready, timeout_o;

  int n_chk = 0;
  int n_fail = 0;
  int aw_cnt, w_cnt;

  axi_lite_arb2 #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst),
    .m0_awaddr(m_awaddr[0]), .m0_awvalid(m_awvalid[0]), .m0_awready(m_awready[0]),
    .m0_wdata(m_wdata[0]), .m0_wstrb(m_wstrb[0]), .m0_wvalid(m_wvalid[0]), .m0_wready(m_wready[0]),
    .m0_bresp(m_bresp[0]), .m0_bvalid(m_bvalid[0]), .m0_bready(m_bready[0]),
    .m0_araddr(m_araddr[0]), .m0_arvalid(m_arvalid[0]), .m0_arready(m_arready[0]),
    .m0_rdata(m_rdata[0]), .m0_rresp(m_rresp[0]), .m0_rvalid(m_rvalid[0]), .m0_rready(m_rready[0]),
    .m1_awaddr(m_awaddr[1]), .m1_awvalid(m_awvalid[1]), .m1_awready(m_awready[1]),
    .m1_wdata(m_wdata[1]), .m1_wstrb(m_wstrb[1]), .m1_wvalid(m_wvalid[1]), .m1_wready(m_wready[1]),
    .m1_bresp(m_bresp[1]), .m1_bvalid(m_bvalid[1]), .m1_bready(m_bready[1]),
    .m1_araddr(m_araddr[1]), .m1_arvalid(m_arvalid[1]), .m1_arready(m_arready[1]),
    .m1_rdata(m_rdata[1]), .m1_rresp(m_rresp[1]), .m1_rvalid(m_rvalid[1]), .m1_rready(m_rready[1]),
    .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
    .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
    .grant_o(grant_o), .timeout_o(timeout_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // op: 0 none, 1 write, 2 read
  task automatic set_req(input int n, input logic [1:0] op, input logic [31:0] addr,
                         input logic [31:0] data, input logic [3:0] strb);
    if (op == 2'd1) begin
      m_awaddr[n] = addr; m_awvalid[n] = 1'b1;
      m_wdata[n] = data; m_wstrb[n] = strb; m_wvalid[n] = 1'b1;
    end else if (op == 2'd2) begin
      m_araddr[n] = addr; m_arvalid[n] = 1'b1;
    end
  endtask

  // Runs one granted transaction for master n with an inline slave model.
  // Slave answers reads with ~addr; b/r valid appear no earlier than b_at/r_at.
  task automatic serve(input int n, input logic is_wr, input logic [31:0] addr,
                       input logic [31:0] data, input logic [3:0] strb,
                       input logic [1:0] sresp, input logic [1:0] exp_resp,
                       input logic [31:0] exp_rdata, input int w_delay,
                       input int b_at, input int r_at, output int to_cycle);
    int o;
    logic done, aw_seen, w_seen, ar_seen, b_given, r_given;
    logic hs_maw, hs_mw, hs_mar, hs_mb, hs_mr, hs_saw, hs_sw, hs_sar, hs_sb, hs_sr;
    o = 1 - n;
    done = 0; aw_seen = 0; w_seen = 0; ar_seen = 0; b_given = 0; r_given = 0;
    to_cycle = -1; aw_cnt = 0; w_cnt = 0;
    m_bready[n] = 1'b1; m_rready[n] = 1'b1;
    s_awready = 1'b1; s_arready = 1'b1; s_bvalid = 1'b0; s_rvalid = 1'b0;
    for (int c = 0; c < 40 && !done; c++) begin
      s_wready = (c >= w_delay);
      #1;
      hs_maw = m_awvalid[n] & m_awready[n];
      hs_mw  = m_wvalid[n] & m_wready[n];
      hs_mar = m_arvalid[n] & m_arready[n];
      hs_mb  = m_bvalid[n] & m_bready[n];
      hs_mr  = m_rvalid[n] & m_rready[n];
      hs_saw = s_awvalid & s_awready;
      hs_sw  = s_wvalid & s_wready;
      hs_sar = s_arvalid & s_arready;
      hs_sb  = s_bvalid & s_bready;
      hs_sr  = s_rvalid & s_rready;
      if (timeout_o && to_cycle < 0) to_cycle = c;
      chk("other_master_quiet",
          {59'd0, m_awready[o], m_wready[o], m_bvalid[o], m_arready[o], m_rvalid[o]}, 64'd0);
      if (hs_saw) begin aw_cnt++; chk("s_awaddr", s_awaddr, addr); end
      if (hs_sw) begin
        w_cnt++;
        chk("s_wdata", s_wdata, data);
        chk("s_wstrb", s_wstrb, strb);
      end
      if (aw_seen && !w_seen) chk("s_awvalid_after_aw", s_awvalid, 1'b0);
      if (hs_sar) chk("s_araddr", s_araddr, addr);
      if (hs_mb) begin chk("m_bresp", m_bresp[n], exp_resp); done = 1; end
      if (hs_mr) begin
        chk("m_rresp", m_rresp[n], exp_resp);
        chk("m_rdata", m_rdata[n], exp_rdata);
        done = 1;
      end
      tick();
      if (hs_maw) m_awvalid[n] = 1'b0;
      if (hs_mw)  m_wvalid[n] = 1'b0;
      if (hs_mar) m_arvalid[n] = 1'b0;
      if (hs_saw) aw_seen = 1;
      if (hs_sw)  w_seen = 1;
      if (hs_sar) ar_seen = 1;
      if (hs_sb)  s_bvalid = 1'b0;
      if (hs_sr)  s_rvalid = 1'b0;
      if (aw_seen && w_seen && !b_given && c + 1 >= b_at) begin
        s_bvalid = 1'b1; s_bresp = sresp; b_given = 1;
      end
      if (ar_seen && !r_given && c + 1 >= r_at) begin
        s_rvalid = 1'b1; s_rdata = ~addr; s_rresp = sresp; r_given = 1;
      end
    end
    chk("response_within_budget", done, 1'b1);
    if (is_wr) chk("one_aw_one_w_at_slave", {aw_cnt[7:0], w_cnt[7:0]}, 16'h0101);
    s_bvalid = 1'b0; s_rvalid = 1'b0;
  endtask

  typedef struct {
    logic [1:0]  op0, op1;
    logic [31:0] a0, a1, d0, d1;
    logic [1:0]  sresp;
    logic [1:0]  g1, g2;
  } vec_t;

  vec_t vecs[5];
  vec_t v;
  int   n, to_c;
  logic [1:0]  op;
  logic [31:0] a, d;

  initial begin
    // Arbitration history: last_grant=1 after reset
    vecs[0] = '{2'd2, 2'd2, 32'h1A10_0010, 32'h2000_0010, 32'h0, 32'h0, 2'b00, 2'b01, 2'b10};
    vecs[1] = '{2'd2, 2'd2, 32'h1A10_0020, 32'h2000_0020, 32'h0, 32'h0, 2'b01, 2'b01, 2'b10};
    vecs[2] = '{2'd1, 2'd0, 32'h1A10_0004, 32'h0, 32'hDEADBEEF, 32'h0, 2'b00, 2'b01, 2'b00};
    vecs[3] = '{2'd2, 2'd1, 32'h1A10_0030, 32'h2000_0030, 32'h0, 32'hCAFE_F00D, 2'b11, 2'b10, 2'b01};
    vecs[4] = '{2'd2, 2'd0, 32'h1A10_0040, 32'h0, 32'h0, 32'h0, 2'b00, 2'b01, 2'b00};

    rst = 1'b1;
    m_awvalid = '0; m_wvalid = '0; m_arvalid = '0; m_bready = '1; m_rready = '1;
    for (int i = 0; i < 2; i++) begin
      m_awaddr[i] = '0; m_wdata[i] = '0; m_wstrb[i] = '0; m_araddr[i] = '0;
    end
    s_awready = 1'b0; s_wready = 1'b0; s_arready = 1'b0;
    s_bvalid = 1'b0; s_bresp = 2'b00; s_rvalid = 1'b0; s_rdata = '0; s_rresp = 2'b00;
    tick(); tick();
    chk("reset_grant", grant_o, 2'b00);
    chk("reset_timeout", timeout_o, 1'b0);
    chk("reset_slave_ctrl", {s_awvalid, s_wvalid, s_arvalid, s_bready, s_rready}, 5'd0);
    chk("reset_master_ctrl", {m_awready, m_wready, m_bvalid, m_arready, m_rvalid}, 10'd0);
    chk("reset_data", {s_awaddr, s_wdata, s_araddr, m_rdata[0]}, 128'd0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 5; i++) begin
      v = vecs[i];
      set_req(0, v.op0, v.a0, v.d0, 4'hF);
      set_req(1, v.op1, v.a1, v.d1, 4'hF);
      #1;
      chk("idle_before_grant", grant_o, 2'b00);
      tick();
      chk("first_grant", grant_o, v.g1);
      for (int k = 0; k < 2; k++) begin
        if (k == 1) begin
          if (v.g2 == 2'b00) break;
          chk("idle_gap", grant_o, 2'b00);
          tick();
          chk("second_grant", grant_o, v.g2);
        end
        n  = (k == 0) ? int'(v.g1[1]) : int'(v.g2[1]);
        op = n ? v.op1 : v.op0;
        a  = n ? v.a1 : v.a0;
        d  = n ? v.d1 : v.d0;
        serve(n, op == 2'd1, a, d, 4'hF, v.sresp, v.sresp, ~a, 0, 0, 0, to_c);
        chk("no_timeout", to_c < 0, 1'b1);
      end
      chk("idle_after", grant_o, 2'b00);
    end

    // Split AW/W: slave takes W three cycles after AW
    set_req(0, 2'd1, 32'h1A10_0050, 32'h1234_5678, 4'h3);
    tick();
    chk("split_grant", grant_o, 2'b01);
    serve(0, 1'b1, 32'h1A10_0050, 32'h1234_5678, 4'h3, 2'b00, 2'b00, 32'h0, 3, 0, 0, to_c);

    // B handshake on the last counted cycle wins over the timeout
    set_req(0, 2'd1, 32'h1A10_0060, 32'h0BAD_CAFE, 4'hF);
    tick();
    serve(0, 1'b1, 32'h1A10_0060, 32'h0BAD_CAFE, 4'hF, 2'b01, 2'b01, 32'h0, 0, 15, 0, to_c);
    chk("expiry_hs_no_pulse", to_c < 0, 1'b1);
    #1;
    chk("expiry_hs_timeout_low", timeout_o, 1'b0);

    // One cycle later the write times out: SLVERR, pulse at cycle 16
    set_req(1, 2'd1, 32'h2000_0070, 32'h7777_0000, 4'hF);
    tick();
    serve(1, 1'b1, 32'h2000_0070, 32'h7777_0000, 4'hF, 2'b00, 2'b10, 32'h0, 0, 16, 0, to_c);
    chk("write_timeout_cycle", to_c, 16);

    // Read timeout with master holding rready low; late slave rvalid drained
    set_req(1, 2'd2, 32'h2000_0080, 32'h0, 4'h0);
    m_rready[1] = 1'b0; s_arready = 1'b1; s_rvalid = 1'b0;
    tick();
    chk("rd_to_grant", grant_o, 2'b10);
    to_c = -1;
    for (int c = 0; c < 16; c++) begin
      #1;
      if (timeout_o && to_c < 0) to_c = c;
      a[0] = m_arvalid[1] & m_arready[1];
      tick();
      if (a[0]) m_arvalid[1] = 1'b0;
    end
    chk("rd_to_not_early", to_c < 0, 1'b1);
    chk("rd_to_pulse", timeout_o, 1'b1);
    chk("rd_to_rvalid", m_rvalid[1], 1'b1);
    chk("rd_to_rresp", m_rresp[1], 2'b10);
    chk("rd_to_rdata", m_rdata[1], 32'h0);
    s_rvalid = 1'b1; s_rdata = 32'h5555_AAAA; s_rresp = 2'b00;
    #1;
    chk("rd_to_drain_ready", s_rready, 1'b1);
    chk("rd_to_late_not_fwd", {m_rdata[1], m_rresp[1]}, {32'h0, 2'b10});
    tick();
    s_rvalid = 1'b0;
    #1;
    chk("rd_to_pulse_one_cycle", timeout_o, 1'b0);
    chk("rd_to_err_held", m_rvalid[1], 1'b1);
    m_rready[1] = 1'b1;
    tick();
    chk("rd_to_back_idle", {grant_o, m_rvalid[1]}, 3'b000);

    // Reset during R_DATA, then a tie must go to master 0 again
    set_req(0, 2'd2, 32'h1A10_0090, 32'h0, 4'h0);
    s_arready = 1'b1; s_rvalid = 1'b0;
    tick();
    tick();
    m_arvalid[0] = 1'b0;
    #1;
    chk("rdata_state_rready", s_rready, 1'b1);
    rst = 1'b1;
    #1;
    chk("midrst_grant", grant_o, 2'b00);
    chk("midrst_outputs", {s_rready, s_arvalid, s_awvalid, s_wvalid, m_rvalid, m_arready, timeout_o}, 9'd0);
    tick();
    rst = 1'b0;
    set_req(0, 2'd2, 32'h1A10_00A0, 32'h0, 4'h0);
    set_req(1, 2'd2, 32'h2000_00A0, 32'h0, 4'h0);
    tick();
    chk("post_reset_tie_m0", grant_o, 2'b01);
    serve(0, 1'b0, 32'h1A10_00A0, 32'h0, 4'h0, 2'b00, 2'b00, ~32'h1A10_00A0, 0, 0, 0, to_c);
    tick();
    chk("post_reset_then_m1", grant_o, 2'b10);
    serve(1, 1'b0, 32'h2000_00A0, 32'h0, 4'h0, 2'b00, 2'b00, ~32'h2000_00A0, 0, 0, 0, to_c);
    chk("final_idle", grant_o, 2'b00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
